bus_arbiter: RTL and testbench

Round-robin arbiter and drive-enable sequencer for the processor's shared tri-state data bus. It sits directly upstream of the per-source TRI_STATE buffers. It receives bus requests from up to N sources and produces one registered, one-hot enable per source, which connects straight to each buffer's EN input. A mandatory one-cycle turnaround between owners guarantees that no two buffers ever drive the bus in the same or adjacent cycles.

---
 rtl/bus_arbiter.sv | 111 +++++++++++
 tb/tb_bus_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and drive-enable sequencer for a shared tri-state bus.
// Grants one source at a time. Inserts a mandatory one-cycle dead slot
// between owners. Caps any single tenure at MAX_HOLD cycles.
module bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [N-1:0]         REQ,
  output logic [N-1:0]         GNT,
  output logic [N-1:0]         BUS_EN,
  output logic [$clog2(N)-1:0] OWNER,
  output logic                 BUSY
);

  localparam int OW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_TURN = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [OW-1:0] last;
  logic [N-1:0]  gnt_q;
  logic [OW-1:0] owner_q;
  logic          busy_q;

  logic          win_found;
  logic [OW-1:0] win_idx;
  logic          hold_done;
  logic          release_now;

  // Round-robin search: first requester after the previous owner, wrapping
  // so that the previous owner itself is examined last.
  always_comb begin
    // NOTE: every signal written here gets a default first; otherwise a path
    // that skips the assignment would infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!win_found && REQ[(int'(last) + k) % N]) begin
        win_found = 1'b1;
        win_idx   = OW'((int'(last) + k) % N);
      end
    end
  end

  // Tenure ends when the owner lets go or has used its full allowance.
  assign hold_done   = (cnt == CW'(MAX_HOLD));
  assign release_now = !REQ[owner_q] || hold_done;

  // Ownership state machine; all outputs are taken straight from flops.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!RST_N) begin
      state   <= S_IDLE;
      cnt     <= '0;
      last    <= OW'(N - 1);
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        // Idle and the dead cycle both arbitrate the same way; they differ
        // only in whether BUSY was high while sitting in them.
        S_IDLE, S_TURN: begin
          if (win_found) begin
            state   <= S_OWN;
            gnt_q   <= N'(1) << win_idx;
            owner_q <= win_idx;
            cnt     <= CW'(1);
            busy_q  <= 1'b1;
          end else begin
            state   <= S_IDLE;
            gnt_q   <= '0;
            cnt     <= '0;
            busy_q  <= 1'b0;
          end
        end
        S_OWN: begin
          if (release_now) begin
            state  <= S_TURN;
            gnt_q  <= '0;
            last   <= owner_q;
            cnt    <= '0;
            busy_q <= 1'b1;
          end else begin
            cnt    <= cnt + CW'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          gnt_q  <= '0;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Drive enables are the grant flops themselves, so they can never diverge.
  assign GNT    = gnt_q;
  assign BUS_EN = gnt_q;
  assign OWNER  = owner_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// requests, checked against a tenure-level reference model via a scoreboard.
module tb_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int OW       = $clog2(N);

  logic          CLK;
  logic          RST_N;
  logic [N-1:0]  REQ;
  logic [N-1:0]  GNT;
  logic [N-1:0]  BUS_EN;
  logic [OW-1:0] OWNER;
  logic          BUSY;

  bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .REQ    (REQ),
    .GNT    (GNT),
    .BUS_EN (BUS_EN),
    .OWNER  (OWNER),
    .BUSY   (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [OW-1:0] owner;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model, in terms of tenures: who holds the bus, for how long,
  // and whether the previous tenure just ended (dead slot still counts busy).
  int m_owner;   // -1 when nobody holds the bus
  int m_len;
  int m_prev;    // previous owner, sets round-robin priority
  int m_shown;   // index reported on OWNER
  bit m_gap;

  always @(posedge CLK or negedge RST_N) begin
    exp_t e;
    if (!RST_N) begin
      m_owner = -1;
      m_len   = 0;
      m_prev  = N - 1;
      m_shown = 0;
      m_gap   = 1'b0;
      exp_q.delete();
    end else begin
      if (m_owner >= 0) begin
        if (!REQ[m_owner] || m_len == MAX_HOLD) begin
          m_prev  = m_owner;
          m_owner = -1;
          m_gap   = 1'b1;
        end else begin
          m_len++;
        end
      end else begin
        m_gap = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (m_owner < 0 && REQ[(m_prev + k) % N]) begin
            m_owner = (m_prev + k) % N;
            m_len   = 1;
            m_shown = m_owner;
          end
        end
      end
      e.gnt   = (m_owner >= 0) ? N'(1) << m_owner : '0;
      e.owner = OW'(m_shown);
      e.busy  = (m_owner >= 0) || m_gap;
      exp_q.push_back(e);
    end
  end

  // Monitor: pops expectations, plus per-cycle bus-safety and fairness checks.
  logic [N-1:0] prev_gnt;
  int           run_len;
  int           wait_c[N];

  always @(negedge CLK) begin
    exp_t e;
    int   worst;
    if (!RST_N) begin
      prev_gnt = '0;
      run_len  = 0;
      for (int i = 0; i < N; i++) wait_c[i] = 0;
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs{gnt,en,owner,busy}", {21'd0, GNT, BUS_EN, OWNER, BUSY},
              {21'd0, e.gnt, e.gnt, e.owner, e.busy});
      end
      check("en_onehot_eq_gnt", 32'($onehot0(BUS_EN) && (BUS_EN == GNT)), 32'd1);
      check("dead_cycle_between_owners",
            32'((GNT != 0) && (prev_gnt != 0) && (GNT != prev_gnt)), 32'd0);
      if (GNT != 0 && GNT == prev_gnt) run_len++;
      else if (GNT != 0)               run_len = 1;
      else                             run_len = 0;
      check("max_hold", 32'(run_len <= MAX_HOLD), 32'd1);
      worst = 0;
      for (int i = 0; i < N; i++) begin
        if (REQ[i] && !GNT[i]) wait_c[i]++;
        else                   wait_c[i] = 0;
        if (wait_c[i] > worst) worst = wait_c[i];
      end
      check("starvation_bound", 32'(worst <= N * (MAX_HOLD + 1)), 32'd1);
      prev_gnt = GNT;
    end
  end

  // Stimulus moves just after the falling edge, well clear of the rising edge.
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  logic [N-1:0] cont_exp [12];
  int           gcnt [N];

  initial begin
    cont_exp = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
    RST_N = 1'b0;
    REQ   = 4'b1111;
    repeat (3) tick();
    check("reset_gnt",    32'(GNT),    32'd0);
    check("reset_bus_en", 32'(BUS_EN), 32'd0);
    check("reset_busy",   32'(BUSY),   32'd0);
    check("reset_owner",  32'(OWNER),  32'd0);

    // Contention right after reset; each source lets go after 2 grant cycles.
    RST_N = 1'b1;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    for (int s = 0; s < 12; s++) begin
      tick();
      check($sformatf("contention[%0d]", s), 32'(GNT), 32'(cont_exp[s]));
      for (int i = 0; i < N; i++) begin
        if (GNT[i]) begin
          gcnt[i]++;
          if (gcnt[i] == 2) REQ[i] = 1'b0;
        end
      end
    end
    REQ = '0;
    repeat (3) tick();

    // Single hog: MAX_HOLD cycles, one dead cycle, then regranted.
    REQ = 4'b0001;
    for (int s = 0; s < 2 * MAX_HOLD + 1; s++) begin
      tick();
      check($sformatf("hog[%0d]", s), 32'(GNT), (s == MAX_HOLD) ? 32'd0 : 32'd1);
    end
    REQ = '0;
    repeat (3) tick();

    // Early release with another source waiting.
    REQ = 4'b0010;
    tick(); check("early_g1", 32'(GNT), 32'b0010);
    REQ = 4'b0110;
    tick(); check("early_g2", 32'(GNT), 32'b0010);
    tick(); check("early_g3", 32'(GNT), 32'b0010);
    REQ = 4'b0100;
    tick(); check("early_turn_gnt",  32'(GNT),  32'd0);
            check("early_turn_busy", 32'(BUSY), 32'd1);
    tick(); check("early_new_gnt",   32'(GNT),   32'b0100);
            check("early_new_owner", 32'(OWNER), 32'd2);

    // Asynchronous reset between edges while source 2 owns the bus.
    REQ = 4'b0101;
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_gnt",    32'(GNT),    32'd0);
    check("async_rst_bus_en", 32'(BUS_EN), 32'd0);
    check("async_rst_busy",   32'(BUSY),   32'd0);
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    check("post_rst_gnt", 32'(GNT), 32'b0001);

    // Random requests: each bit toggles with probability 1/6 per cycle.
    for (int c = 0; c < 10000; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) REQ[i] = ~REQ[i];
    end
    REQ = '0;
    repeat (MAX_HOLD + 3) tick();
    check("idle_after_drain_busy", 32'(BUSY), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
